// File: rtl/lcd_fb_pkg.sv
// Shared types, default geometry and the bank rotation rule for the LCD frame buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lcd_fb_pkg;

    typedef enum logic {
        W_IDLE   = 1'b0,
        W_ACTIVE = 1'b1
    } wr_state_t;

    localparam int DEF_H_ACTIVE = 160;
    localparam int DEF_V_ACTIVE = 144;
    localparam int FRAME_PIX    = DEF_H_ACTIVE * DEF_V_ACTIVE;

    localparam logic [14:0] DEF_BLANK_COLOR = 15'h7FFF;

    // Bank the writer moves to after completing a frame into 'latest'.
    // Three banks: never the freshly completed bank nor the one being scanned out.
    // Two banks: simple ping-pong. One bank: always bank 0.
    function automatic logic [1:0] next_bank(input logic [1:0] latest,
                                             input logic [1:0] rd,
                                             input int         num_banks);
        logic [1:0] nb;
        nb = 2'd0;
        if (num_banks == 3) begin
            if (latest == rd) begin
                nb = (latest == 2'd2) ? 2'd0 : latest + 2'd1;
            end else begin
                // Bank indices sum to 3, so the remaining one is 3 - a - b.
                nb = 2'd3 - latest - rd;
            end
        end else if (num_banks == 2) begin
            nb = {1'b0, ~latest[0]};
        end
        return nb;
    endfunction

endpackage

// File: rtl/lcd_fb_ram.sv
// Simple dual-port, single-clock, read-first pixel RAM holding every frame bank.
// Latency: 1 cycle from rd_en/rd_addr to rd_data.
// Backpressure: none; every port strobe is accepted each cycle.
module lcd_fb_ram #(
    parameter int DATA_W = 15,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_sys,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write and registered read in one block: a same-address read sees the old word.
    always_ff @(posedge clk_sys) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/lcd_frame_buffer.sv
// Multi-bank LCD frame buffer: captures the pixel stream, scans out the newest complete frame.
// Latency: rd_data/rd_valid 2 cycles after rd_en (RAM register, then output register).
// Backpressure: none; writes and reads are accepted every cycle, overruns are flagged in status.
module lcd_frame_buffer
    import lcd_fb_pkg::*;
#(
    parameter int               PIX_W       = 15,
    parameter int               H_ACTIVE    = DEF_H_ACTIVE,
    parameter int               V_ACTIVE    = DEF_V_ACTIVE,
    parameter int               NUM_BANKS   = 3,
    parameter logic [PIX_W-1:0] BLANK_COLOR = PIX_W'(DEF_BLANK_COLOR)
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             wr_frame_start,
    input  logic             wr_en,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             wr_freeze,
    input  logic             rd_frame_start,
    input  logic             rd_en,
    output logic [PIX_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             frame_valid,
    output logic [7:0]       frames_dropped,
    output logic             rd_underrun,
    input  logic             clr_status
);

    localparam int FPIX   = H_ACTIVE * V_ACTIVE;
    // Wide enough to also hold FPIX, which marks "reader past end of frame".
    localparam int PTR_W  = $clog2(FPIX + 1);
    localparam int DEPTH  = NUM_BANKS * FPIX;
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FPIX - 1);
    localparam logic [PTR_W-1:0] END_PTR  = PTR_W'(FPIX);

    wr_state_t         wr_state;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [1:0]        wr_bank;
    logic [1:0]        latest_bank;
    logic [1:0]        rd_bank;

    logic              wr_start_ok;
    logic              mem_we;
    logic              wr_done;
    logic              wr_drop;
    logic              rd_in_frame;
    logic              rd_over;
    logic              ram_re;
    logic [1:0]        rd_bank_nxt;
    logic [1:0]        rd_bank_eff;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  ram_rd_dat;

    logic              s1_vld;
    logic              s1_blank;

    // A frame start wins over a same-cycle pixel strobe; freeze masks both.
    assign wr_start_ok = wr_frame_start && !wr_freeze;
    assign mem_we      = wr_en && !wr_freeze && !wr_frame_start && (wr_state == W_ACTIVE);
    assign wr_done     = mem_we && (wr_ptr == LAST_PTR);
    assign wr_drop     = wr_start_ok && (wr_state == W_ACTIVE);

    assign rd_in_frame = (rd_ptr != END_PTR);
    assign rd_over     = rd_en && !rd_in_frame;
    assign ram_re      = rd_en && rd_in_frame;

    // A frame completing in the same cycle as a scan-out restart is handed straight to the reader.
    assign rd_bank_nxt = wr_done ? wr_bank : latest_bank;
    assign rd_bank_eff = rd_frame_start ? rd_bank_nxt : rd_bank;

    assign wr_addr = ADDR_W'(wr_bank) * ADDR_W'(FPIX) + ADDR_W'(wr_ptr);
    assign rd_addr = ADDR_W'(rd_bank) * ADDR_W'(FPIX) + ADDR_W'(rd_ptr);

    lcd_fb_ram #(
        .DATA_W (PIX_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_sys (clk_sys),
        .wr_en   (mem_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (ram_re),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_dat)
    );

    // Writer FSM: fill the current bank, publish it on the last pixel, then rotate banks.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_state    <= W_IDLE;
            wr_ptr      <= '0;
            wr_bank     <= 2'd0;
            latest_bank <= 2'd0;
            frame_valid <= 1'b0;
        end else if (wr_start_ok) begin
            // A restart mid-frame simply rewinds into the same bank.
            wr_state <= W_ACTIVE;
            wr_ptr   <= '0;
        end else if (mem_we) begin
            if (wr_done) begin
                wr_state    <= W_IDLE;
                wr_ptr      <= '0;
                latest_bank <= wr_bank;
                frame_valid <= 1'b1;
                wr_bank     <= next_bank(wr_bank, rd_bank_eff, NUM_BANKS);
            end else begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    // Status counters; a clear beats any same-cycle increment or set.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            frames_dropped <= 8'd0;
            rd_underrun    <= 1'b0;
        end else if (clr_status) begin
            frames_dropped <= 8'd0;
            rd_underrun    <= 1'b0;
        end else begin
            if (wr_drop && (frames_dropped != 8'hFF)) begin
                frames_dropped <= frames_dropped + 8'd1;
            end
            if (rd_over) begin
                rd_underrun <= 1'b1;
            end
        end
    end

    // Scan-out pointer: latch the newest bank on frame start, stop at the end of the frame.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rd_bank <= 2'd0;
            rd_ptr  <= '0;
        end else if (rd_frame_start) begin
            rd_bank <= rd_bank_nxt;
            rd_ptr  <= '0;
        end else if (ram_re) begin
            rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Output pipeline: track the request alongside the RAM read, substitute blank where needed.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld   <= 1'b0;
            s1_blank <= 1'b1;
            rd_valid <= 1'b0;
            rd_data  <= BLANK_COLOR;
        end else begin
            s1_vld   <= rd_en;
            s1_blank <= !frame_valid || !rd_in_frame;
            rd_valid <= s1_vld;
            if (s1_vld) begin
                rd_data <= s1_blank ? BLANK_COLOR : ram_rd_dat;
            end
        end
    end

endmodule

// File: tb/tb_lcd_frame_buffer.sv
// Scoreboard bench for lcd_frame_buffer on a small 20x12, three-bank geometry.
// Latency: expects each read 2 cycles after its rd_en.
// Backpressure: none exercised; the DUT has no stall path.
module tb_lcd_frame_buffer;

    localparam int          H     = 20;
    localparam int          V     = 12;
    localparam int          FP    = H * V;
    localparam logic [14:0] BLANK = 15'h7FFF;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        wr_frame_start;
    logic        wr_en;
    logic [14:0] wr_data;
    logic        wr_freeze;
    logic        rd_frame_start;
    logic        rd_en;
    logic [14:0] rd_data;
    logic        rd_valid;
    logic        frame_valid;
    logic [7:0]  frames_dropped;
    logic        rd_underrun;
    logic        clr_status;

    int          n_tot = 0;
    int          n_bad = 0;
    logic [14:0] sb [$];
    logic [14:0] last_exp = BLANK;
    logic [14:0] mon_e;
    bit          mon_on = 1'b0;
    logic        d1;
    logic        d2;

    always #5 clk_sys = ~clk_sys;

    lcd_frame_buffer #(
        .PIX_W       (15),
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .NUM_BANKS   (3),
        .BLANK_COLOR (BLANK)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .wr_frame_start (wr_frame_start),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .wr_freeze      (wr_freeze),
        .rd_frame_start (rd_frame_start),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .frame_valid    (frame_valid),
        .frames_dropped (frames_dropped),
        .rd_underrun    (rd_underrun),
        .clr_status     (clr_status)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] pix(input int id, input int p);
        return 15'(id * 1024 + p);
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wr_start();
        wr_frame_start = 1'b1;
        tick();
        wr_frame_start = 1'b0;
    endtask

    task automatic wr_px(input logic [14:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic rd_start();
        rd_frame_start = 1'b1;
        tick();
        rd_frame_start = 1'b0;
    endtask

    task automatic rd_px(input logic [14:0] e);
        rd_en = 1'b1;
        sb.push_back(e);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        chk("drain", sb.size(), 0);
    endtask

    task automatic clr_pulse();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
    endtask

    // Expected rd_valid: rd_en delayed by two clocks.
    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            d1 <= 1'b0;
            d2 <= 1'b0;
        end else begin
            d1 <= rd_en;
            d2 <= d1;
        end
    end

    // Scoreboard consumer, sampled away from the active edge.
    always @(negedge clk_sys) begin
        if (mon_on) begin
            chk("rd_valid", rd_valid, d2);
            if (d2) begin
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("rd_data", rd_data, mon_e);
                    last_exp = mon_e;
                end
            end else begin
                chk("rd_hold", rd_data, last_exp);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", n_tot, n_bad);
        $fatal(1);
    end

    initial begin
        reset_n        = 1'b0;
        wr_frame_start = 1'b0;
        wr_en          = 1'b0;
        wr_data        = '0;
        wr_freeze      = 1'b0;
        rd_frame_start = 1'b0;
        rd_en          = 1'b0;
        clr_status     = 1'b0;

        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("rst_rd_data", rd_data, BLANK);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_dropped", frames_dropped, 0);
        chk("rst_underrun", rd_underrun, 0);
        tick();
        reset_n  = 1'b1;
        last_exp = BLANK;
        mon_on   = 1'b1;

        // No frame stored yet: reads return blank.
        rd_start();
        repeat (4) rd_px(BLANK);
        drain();
        chk("t1_frame_valid", frame_valid, 0);

        // First complete frame lands in bank 0.
        wr_start();
        for (int p = 0; p < FP; p++) wr_px(pix(0, p));
        tick();
        chk("t2_frame_valid", frame_valid, 1);
        chk("t2_dropped", frames_dropped, 0);

        // Slow scan of bank 0 while the writer drops a partial, then fills banks 1 and 2.
        rd_start();
        fork
            begin
                for (int p = 0; p < FP; p++) begin
                    rd_px(pix(0, p));
                    tick();
                    tick();
                end
            end
            begin
                wr_start();
                for (int p = 0; p < 100; p++) wr_px(pix(5, p));
                wr_start();
                for (int p = 0; p < FP; p++) wr_px(pix(1, p));
                wr_start();
                for (int p = 0; p < FP; p++) wr_px(pix(2, p));
            end
        join
        drain();
        chk("t3_underrun_clear", rd_underrun, 0);
        chk("t3_dropped", frames_dropped, 1);

        // One read past the end of the frame.
        rd_px(BLANK);
        drain();
        chk("t6_underrun_set", rd_underrun, 1);
        clr_pulse();
        chk("t6_underrun_clr", rd_underrun, 0);
        chk("t6_dropped_clr", frames_dropped, 0);

        // Newest frame is bank 2; meanwhile write a partial, restart, and a frozen stretch.
        rd_start();
        fork
            begin
                for (int p = 0; p < FP; p++) begin
                    rd_px(pix(2, p));
                    tick();
                end
            end
            begin
                wr_start();
                for (int p = 0; p < 100; p++) wr_px(pix(6, p));
                wr_start();
                for (int p = 0; p < 120; p++) wr_px(pix(3, p));
                wr_freeze = 1'b1;
                for (int i = 0; i < 50; i++) begin
                    wr_en          = 1'b1;
                    wr_data        = pix(7, i);
                    wr_frame_start = (i == 25);
                    tick();
                    wr_frame_start = 1'b0;
                end
                wr_en     = 1'b0;
                wr_freeze = 1'b0;
                for (int p = 120; p < FP; p++) wr_px(pix(3, p));
            end
        join
        drain();
        chk("t5_dropped", frames_dropped, 1);
        chk("t5_frame_valid", frame_valid, 1);

        // Restarted frame must read back clean, with no partial or frozen pixels.
        rd_start();
        for (int p = 0; p < FP; p++) rd_px(pix(3, p));
        drain();
        chk("t5_underrun_clear", rd_underrun, 0);

        // Clear in the same cycle as an over-read: clear wins.
        clr_status = 1'b1;
        rd_px(BLANK);
        clr_status = 1'b0;
        drain();
        chk("clr_prio_underrun", rd_underrun, 0);
        chk("clr_prio_dropped", frames_dropped, 0);

        // Drop counter saturates.
        for (int i = 0; i < 257; i++) wr_start();
        tick();
        chk("dropped_sat", frames_dropped, 255);
        clr_pulse();
        chk("dropped_sat_clr", frames_dropped, 0);

        // Reset in the middle of a frame: nothing valid afterwards.
        for (int i = 0; i < 50; i++) wr_px(pix(4, i));
        mon_on  = 1'b0;
        reset_n = 1'b0;
        @(negedge clk_sys);
        chk("mid_rst_frame_valid", frame_valid, 0);
        chk("mid_rst_rd_valid", rd_valid, 0);
        chk("mid_rst_rd_data", rd_data, BLANK);
        chk("mid_rst_dropped", frames_dropped, 0);
        tick();
        reset_n  = 1'b1;
        last_exp = BLANK;
        mon_on   = 1'b1;
        rd_start();
        repeat (3) rd_px(BLANK);
        drain();
        chk("post_rst_frame_valid", frame_valid, 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/lcd_frame_buffer.md
Name: lcd_frame_buffer

Overview:
Parametrised multi-bank frame buffer sitting between the GB/GBC pixel pipeline and the video scan-out / pixel generator.
- Write side accepts a pixel stream gated by the LCD pixel enable.
- Read side is driven by the scan-out timing and always reads the most recent complete frame.
- Generalises the single-buffer scheme to 1/2/3 banks, with tear-free triple buffering, partial-frame discard and status counters.
- Single clock domain; the downstream CDC is out of scope.

Parameters:
PIX_W, 15, pixel width in bits (RGB555 for GBC, low 2 bits used for DMG)
H_ACTIVE, 160, pixels per line
V_ACTIVE, 144, lines per frame
NUM_BANKS, 3, number of frame banks; legal values 1, 2, 3
BLANK_COLOR, 15'h7FFF, value output when no valid frame or on underrun

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
wr_frame_start  in  1  pulse; start of a new LCD frame (rising LCD vsync)
wr_en  in  1  pixel write strobe (ce & lcd_clkena)
wr_data  in  PIX_W  pixel data
wr_freeze  in  1  ignore wr_en and wr_frame_start (SGB freeze / LCD-off hold)
rd_frame_start  in  1  pulse; scan-out starts a new frame
rd_en  in  1  request next pixel
rd_data  out  PIX_W  pixel output
rd_valid  out  1  rd_data valid for the request issued 2 cycles earlier
frame_valid  out  1  at least one complete frame is stored
frames_dropped  out  8  saturating count of partial frames discarded
rd_underrun  out  1  sticky; rd_en issued past the end of the frame
clr_status  in  1  clears frames_dropped and rd_underrun

Behaviour:
Reset (async, reset_n low):
- rd_data=BLANK_COLOR, rd_valid=0, frame_valid=0, frames_dropped=0, rd_underrun=0.
- All pointers 0; wr_bank=0, latest_bank=0, rd_bank=0; writer state W_IDLE.
- Memory contents are not reset.

Writer FSM (W_IDLE, W_ACTIVE):
- W_IDLE: wr_en ignored. wr_frame_start -> W_ACTIVE, wr_ptr=0.
- W_ACTIVE: each wr_en writes mem[wr_bank][wr_ptr], then wr_ptr++.
- When the write at wr_ptr==H_ACTIVE*V_ACTIVE-1 occurs:
  - latest_bank<=wr_bank, frame_valid<=1, state -> W_IDLE.
  - wr_bank<=next bank:
    - NUM_BANKS=3: the bank that is neither the new latest_bank nor rd_bank.
    - NUM_BANKS=2: the other bank (tearing possible, accepted).
    - NUM_BANKS=1: stays 0.
- wr_frame_start in W_ACTIVE before completion: frames_dropped++ (saturating at 255), wr_ptr=0, same bank reused, state stays W_ACTIVE.
- wr_freeze=1: wr_en and wr_frame_start ignored; FSM state and wr_ptr hold.

Reader:
- rd_frame_start: rd_bank<=latest_bank, rd_ptr<=0.
- If completion and rd_frame_start occur in the same cycle, the reader takes the just-completed bank (bypass).
- rd_en with rd_ptr < H*V: read mem[rd_bank][rd_ptr], then rd_ptr++.
- Latency 2 cycles: RAM read register, then output register; rd_valid mirrors rd_en delayed by 2.
- rd_en with rd_ptr==H*V: no increment, rd_underrun<=1, output BLANK_COLOR.
- frame_valid=0: every read returns BLANK_COLOR.
- rd_data holds its value when rd_valid=0.

Status:
- clr_status has priority over a same-cycle increment or set.

Arithmetic:
- Pointer width = clog2(H*V).
- Address = bank*H*V + ptr, computed with constant multiplies only.

Simultaneous events:
- Same-address read/write across different banks: no hazard.
- Same bank (NUM_BANKS 1/2): read returns old data (read-first RAM).

Reset mid-frame: frame_valid drops to 0, and output is blank until the next full frame completes.

Decomposition:
- Package lcd_fb_pkg: writer state enum {W_IDLE, W_ACTIVE}, FRAME_PIX = H_ACTIVE*V_ACTIVE, a function next_bank(latest, rd, NUM_BANKS), default BLANK_COLOR.
- Sub-module lcd_fb_ram: simple dual-port, single-clock, read-first inferred BRAM, depth NUM_BANKS*FRAME_PIX, width PIX_W, 1-cycle registered read.

Test Plan:
- Reset, then rd_frame_start and 4 rd_en with no frame written -> rd_data=7FFF with rd_valid 2 cycles after each rd_en; frame_valid=0.
- Write full frame with data=ptr[14:0], then rd_frame_start and read all 23040 pixels -> rd_data sequence 0..23039 (mod 2^15), frame_valid=1, no underrun.
- Write 100 pixels, then wr_frame_start, then a full frame -> frames_dropped=1; the read shows only the complete frame, with no pixel 0..99 from the partial write.
- NUM_BANKS=3: reader mid-frame on bank 0, writer completes frames into banks 1 and 2 -> bank 0 data never overwritten during the read; next rd_frame_start reads bank 2.
- wr_freeze=1 for 50 wr_en mid-frame -> wr_ptr unchanged, completion still requires exactly 23040 unfrozen writes.
- 23041st rd_en in one frame -> rd_data=7FFF, rd_underrun=1; clr_status -> rd_underrun=0, frames_dropped=0.
